// File: rtl/broadphase_pair_scheduler_pkg.sv
// Shared widths, body record field offsets and scheduler FSM encoding for the
// broad-phase pair scheduler.
package broadphase_pair_scheduler_pkg;

  localparam int unsigned W      = 19;
  localparam int unsigned IDXW   = 4;
  localparam int unsigned NFIELD = 10;
  localparam int unsigned BODYW  = NFIELD * W;
  localparam int unsigned VERTW  = 8 * W;

  localparam int unsigned V0X  = 0;
  localparam int unsigned V0Y  = 1;
  localparam int unsigned V1X  = 2;
  localparam int unsigned V1Y  = 3;
  localparam int unsigned V2X  = 4;
  localparam int unsigned V2Y  = 5;
  localparam int unsigned V3X  = 6;
  localparam int unsigned V3Y  = 7;
  localparam int unsigned POSX = 8;
  localparam int unsigned POSY = 9;

  typedef logic signed [W-1:0] coord_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_A_REQ,
    S_LOAD_A_WAIT,
    S_LOAD_B_REQ,
    S_LOAD_B_WAIT,
    S_TEST,
    S_ISSUE,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } state_t;

endpackage

// File: rtl/broadphase_pair_scheduler_if.sv
// Body-memory read port and Collide narrow-phase handshake bundled as one bus.
interface broadphase_pair_scheduler_if;
  import broadphase_pair_scheduler_pkg::*;

  logic              body_rd_en;
  logic [IDXW-1:0]   body_rd_addr;
  logic [BODYW-1:0]  body_rd_data;
  logic [IDXW-1:0]   A_nth;
  logic [IDXW-1:0]   B_nth;
  logic [BODYW-1:0]  a_body;
  logic [BODYW-1:0]  b_body;
  logic              collide_start;
  logic              collide_done;

  modport master (
    output body_rd_en, body_rd_addr, A_nth, B_nth, a_body, b_body, collide_start,
    input  body_rd_data, collide_done
  );

  modport slave (
    input  body_rd_en, body_rd_addr, A_nth, B_nth, a_body, b_body, collide_start,
    output body_rd_data, collide_done
  );

endinterface

// File: rtl/broadphase_pair_scheduler_aabb_of_quad.sv
// Combinational axis-aligned bounding box of a four-vertex quad (signed coordinates).
module aabb_of_quad
  import broadphase_pair_scheduler_pkg::*;
(
  input  logic [VERTW-1:0] verts,
  output coord_t           min_x,
  output coord_t           max_x,
  output coord_t           min_y,
  output coord_t           max_y
);

  coord_t vx;
  coord_t vy;

  always_comb begin
    min_x = verts[V0X*W +: W];
    max_x = verts[V0X*W +: W];
    min_y = verts[V0Y*W +: W];
    max_y = verts[V0Y*W +: W];
    vx    = '0;
    vy    = '0;
    for (int unsigned k = 1; k < 4; k++) begin
      vx = verts[(2*k)*W +: W];
      vy = verts[(2*k+1)*W +: W];
      if (vx < min_x) min_x = vx;
      if (vx > max_x) max_x = vx;
      if (vy < min_y) min_y = vy;
      if (vy > max_y) max_y = vy;
    end
  end

endmodule

// File: rtl/broadphase_pair_scheduler.sv
// Sweeps all unordered body pairs once per frame, AABB-culls them and hands
// overlapping pairs to the Collide narrow-phase engine one at a time.
module broadphase_pair_scheduler
  import broadphase_pair_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
)
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic [IDXW:0]               num_bodies,
  broadphase_pair_scheduler_if.master bus,
  output logic                        busy,
  output logic                        sweep_done,
  output logic [7:0]                  pair_count,
  output logic                        err_timeout
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IDXW:0] NUM_ONE = (IDXW+1)'(1);
  localparam logic [IDXW:0] NUM_TWO = (IDXW+1)'(2);

  state_t           state, state_nx;
  logic [IDXW-1:0]  i_idx, j_idx, a_nth, b_nth;
  logic [IDXW:0]    num_r;
  logic [BODYW-1:0] a_body, b_body;
  logic [TW-1:0]    tcnt;
  logic             overlap, j_more, i_more, done_ok, timed_out;
  coord_t           a_min_x, a_max_x, a_min_y, a_max_y;
  coord_t           b_min_x, b_max_x, b_min_y, b_max_y;

  aabb_of_quad u_aabb_a (
    .verts (a_body[VERTW-1:0]),
    .min_x (a_min_x), .max_x (a_max_x), .min_y (a_min_y), .max_y (a_max_y)
  );

  aabb_of_quad u_aabb_b (
    .verts (b_body[VERTW-1:0]),
    .min_x (b_min_x), .max_x (b_max_x), .min_y (b_min_y), .max_y (b_max_y)
  );

  assign overlap   = (a_max_x >= b_min_x) && (b_max_x >= a_min_x) &&
                     (a_max_y >= b_min_y) && (b_max_y >= a_min_y);
  assign j_more    = {1'b0, j_idx} < (num_r - NUM_ONE);
  assign i_more    = {1'b0, i_idx} < (num_r - NUM_TWO);
  // The first WAIT_DONE cycle (tcnt==0) may still see done from the previous pair.
  assign done_ok   = (tcnt != '0) && bus.collide_done;
  assign timed_out = (tcnt == TW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    bus.body_rd_en    = 1'b0;
    bus.body_rd_addr  = '0;
    bus.collide_start = 1'b0;
    sweep_done        = 1'b0;
    case (state)
      S_IDLE:        if (frame_start)
                       state_nx = (num_bodies < NUM_TWO) ? S_FINISH : S_LOAD_A_REQ;
      S_LOAD_A_REQ:  begin
                       bus.body_rd_en   = 1'b1;
                       bus.body_rd_addr = i_idx;
                       state_nx         = S_LOAD_A_WAIT;
                     end
      S_LOAD_A_WAIT: state_nx = S_LOAD_B_REQ;
      S_LOAD_B_REQ:  begin
                       bus.body_rd_en   = 1'b1;
                       bus.body_rd_addr = j_idx;
                       state_nx         = S_LOAD_B_WAIT;
                     end
      S_LOAD_B_WAIT: state_nx = S_TEST;
      S_TEST:        state_nx = overlap ? S_ISSUE : S_NEXT;
      S_ISSUE:       begin
                       bus.collide_start = 1'b1;
                       state_nx          = S_WAIT_DONE;
                     end
      S_WAIT_DONE:   if (done_ok || timed_out) state_nx = S_NEXT;
      S_NEXT:        state_nx = j_more ? S_LOAD_B_REQ : (i_more ? S_LOAD_A_REQ : S_FINISH);
      S_FINISH:      begin
                       sweep_done = 1'b1;
                       state_nx   = S_IDLE;
                     end
      default:       state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_idx       <= '0;
      j_idx       <= '0;
      a_nth       <= '0;
      b_nth       <= '0;
      num_r       <= '0;
      a_body      <= '0;
      b_body      <= '0;
      tcnt        <= '0;
      pair_count  <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (frame_start) begin
          i_idx       <= '0;
          j_idx       <= IDXW'(1);
          pair_count  <= '0;
          err_timeout <= 1'b0;
          num_r       <= num_bodies;
        end
        S_LOAD_A_WAIT: a_body <= bus.body_rd_data;
        S_LOAD_B_WAIT: b_body <= bus.body_rd_data;
        // Indices are latched on the way into ISSUE so they are valid alongside collide_start.
        S_TEST: if (overlap) begin
          a_nth <= i_idx;
          b_nth <= j_idx;
        end
        S_ISSUE: begin
          tcnt <= '0;
          if (pair_count != 8'hFF) pair_count <= pair_count + 8'd1;
        end
        S_WAIT_DONE: begin
          if (!(done_ok || timed_out)) tcnt <= tcnt + TW'(1);
          if (!done_ok && timed_out)   err_timeout <= 1'b1;
        end
        S_NEXT: begin
          if (j_more) begin
            j_idx <= j_idx + IDXW'(1);
          end else if (i_more) begin
            i_idx <= i_idx + IDXW'(1);
            j_idx <= i_idx + IDXW'(2);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.A_nth  = a_nth;
  assign bus.B_nth  = b_nth;
  assign bus.a_body = a_body;
  assign bus.b_body = b_body;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_broadphase_pair_scheduler.sv
// Scoreboard bench: expected pairs and sweep results are queued by the stimulus
// and checked by a monitor whenever collide_start or sweep_done appears.
module tb_broadphase_pair_scheduler;
  import broadphase_pair_scheduler_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_start = 1'b0;
  logic [IDXW:0]   num_bodies = '0;
  logic            busy, sweep_done, err_timeout;
  logic [7:0]      pair_count;

  broadphase_pair_scheduler_if bus ();

  broadphase_pair_scheduler #(.TIMEOUT(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .num_bodies  (num_bodies),
    .bus         (bus),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .pair_count  (pair_count),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [BODYW-1:0] act, input logic [BODYW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { int a; int b; } pair_t;
  typedef struct { int pc; int err; } sweep_t;
  pair_t  pair_q[$];
  sweep_t sweep_q[$];

  logic [BODYW-1:0] mem [16];
  int   cyc = 0, rd_count = 0, start_cyc = 0, sweep_cyc = 0;
  int   done_delay = 0;
  bit   stale_mode = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.body_rd_en) begin
      rd_count         <= rd_count + 1;
      bus.body_rd_data <= mem[bus.body_rd_addr];
    end
  end

  // Collide model: lower done on restart, raise it done_delay cycles later (0 = never).
  initial begin
    bus.collide_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.collide_start) begin
        if (!stale_mode) bus.collide_done = 1'b0;
        if (done_delay > 0) begin
          repeat (done_delay) @(negedge clk);
          bus.collide_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    pair_t  p;
    sweep_t s;
    if (!rst && bus.collide_start) begin
      start_cyc = cyc;
      if (pair_q.size() == 0) check("unexpected_start", 1, 0);
      else begin
        p = pair_q.pop_front();
        check("A_nth", bus.A_nth, p.a);
        check("B_nth", bus.B_nth, p.b);
        check("a_body", bus.a_body, mem[p.a]);
        check("b_body", bus.b_body, mem[p.b]);
      end
    end
    if (!rst && sweep_done) begin
      sweep_cyc = cyc;
      if (sweep_q.size() == 0) check("unexpected_sweep_done", 1, 0);
      else begin
        s = sweep_q.pop_front();
        check("pair_count", pair_count, s.pc);
        check("err_timeout", err_timeout, s.err);
      end
    end
  end

  function automatic logic [BODYW-1:0] box(input int xmin, input int ymin, input int xmax, input int ymax);
    logic [BODYW-1:0] r;
    int v[8];
    v = '{xmax, ymin, xmin, ymin, xmin, ymax, xmax, ymax};
    r = '0;
    for (int k = 0; k < 8; k++) r[k*W +: W] = coord_t'(v[k] * 256);
    return r;
  endfunction

  task automatic expect_pair(input int a, input int b);
    pair_t p;
    p.a = a; p.b = b;
    pair_q.push_back(p);
  endtask

  task automatic expect_sweep(input int pc, input int err);
    sweep_t s;
    s.pc = pc; s.err = err;
    sweep_q.push_back(s);
  endtask

  task automatic run_frame(input int num, input int budget, input bit mid, output int k);
    int n;
    n = num;
    @(negedge clk);
    num_bodies  = n[IDXW:0];
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    k = 1;
    while (!sweep_done && k < budget) begin
      if (mid && k == 15) begin
        check("busy_mid_sweep", busy, 1);
        frame_start = 1'b1;
      end else frame_start = 1'b0;
      @(negedge clk);
      k++;
    end
    frame_start = 1'b0;
    if (!sweep_done) check("sweep_done_within_budget", 0, 1);
    @(negedge clk);
  endtask

  int k, rd_base;
  logic [BODYW-1:0] body_a;

  initial begin
    body_a = box(50, 50, 150, 150);
    for (int m = 0; m < 16; m++) mem[m] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd_en", bus.body_rd_en, 0);
    check("rst_rd_addr", bus.body_rd_addr, 0);
    check("rst_collide_start", bus.collide_start, 0);
    check("rst_A_nth", bus.A_nth, 0);
    check("rst_a_body", bus.a_body, 0);
    check("rst_busy", busy, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_pair_count", pair_count, 0);
    check("rst_err_timeout", err_timeout, 0);
    rst = 1'b0;
    rd_base = rd_count;
    repeat (5) @(negedge clk);
    check("idle_no_reads", rd_count - rd_base, 0);

    // Overlapping pair, done after 10 cycles
    mem[0] = body_a;
    mem[1] = box(100, 0, 200, 100);
    done_delay = 10;
    expect_pair(0, 1);
    expect_sweep(1, 0);
    run_frame(2, 100, 1'b0, k);
    check("busy_after_sweep", busy, 0);

    // Separated, touching, and negative-coordinate overlap
    mem[1] = box(300, 0, 400, 100);
    expect_sweep(0, 0);
    run_frame(2, 100, 1'b0, k);
    mem[1] = box(150, 0, 250, 100);
    expect_pair(0, 1);
    expect_sweep(1, 0);
    run_frame(2, 100, 1'b0, k);
    mem[1] = box(-300, 0, 60, 100);
    expect_pair(0, 1);
    expect_sweep(1, 0);
    run_frame(2, 100, 1'b0, k);

    // Four mutually overlapping bodies, mid-sweep frame_start ignored
    mem[1] = box(100, 0, 200, 100);
    mem[2] = box(-100, -100, 120, 60);
    mem[3] = box(55, 55, 200, 200);
    done_delay = 3;
    expect_pair(0, 1); expect_pair(0, 2); expect_pair(0, 3);
    expect_pair(1, 2); expect_pair(1, 3); expect_pair(2, 3);
    expect_sweep(6, 0);
    run_frame(4, 300, 1'b1, k);

    // Degenerate body counts
    for (int n = 0; n < 2; n++) begin
      rd_base = rd_count;
      expect_sweep(0, 0);
      run_frame(n, 20, 1'b0, k);
      check("small_num_sweep_latency_ok", k <= 2, 1);
      check("small_num_no_reads", rd_count - rd_base, 0);
    end

    // Stale done held high: not accepted in the first WAIT_DONE cycle
    done_delay = 0;
    stale_mode = 1'b1;
    bus.collide_done = 1'b1;
    expect_pair(0, 1);
    expect_sweep(1, 0);
    run_frame(2, 100, 1'b0, k);
    check("stale_done_start_to_sweep", sweep_cyc - start_cyc, 4);
    stale_mode = 1'b0;
    bus.collide_done = 1'b0;

    // Timeout, then sticky error cleared by the next accepted frame
    expect_pair(0, 1);
    expect_sweep(1, 1);
    run_frame(2, 400, 1'b0, k);
    check("err_timeout_sticky", err_timeout, 1);
    expect_sweep(0, 0);
    run_frame(0, 20, 1'b0, k);

    // Async reset while waiting for done
    expect_pair(0, 1);
    @(negedge clk);
    num_bodies  = (IDXW+1)'(2);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int w = 0; w < 50 && !bus.collide_start; w++) @(negedge clk);
    check("start_before_reset", bus.collide_start, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_pair_count", pair_count, 0);
    check("midrst_b_body", bus.b_body, 0);
    check("midrst_B_nth", bus.B_nth, 0);
    @(negedge clk);
    rst = 1'b0;
    rd_base = rd_count;
    repeat (5) @(negedge clk);
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_no_reads", rd_count - rd_base, 0);

    check("pairs_left_in_scoreboard", pair_q.size(), 0);
    check("sweeps_left_in_scoreboard", sweep_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
